wsacc_pe_seq: RTL and testbench
===============================

Name: wsacc_pe_seq

Overview:
Sequencer for one weight-stationary PE: loads a windowElements-deep signed kernel over a valid/ready weight stream, then streams N activation windows through the PE. The PE's combinational MAC result is captured into a 1-entry output buffer with valid/ready. It sits between the layer-level scheduler/DMA and a single PE instance, driving the PE's weight write port and data inputs.

Parameters:
dataWidth, 8, width of each weight and activation element
outputWidth, 32, width of PE result
windowElements, 9, weights per kernel (max 16, 4-bit PE address)
countWidth, 16, width of window-count field

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
start_i  in  1  start pulse, sampled only in IDLE
num_windows_i  in  countWidth  windows to process, latched on start
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle completion pulse
w_valid_i  in  1  weight stream valid
w_ready_o  out  1  weight stream ready
w_data_i  in  dataWidth  weight element
pe_weight_wr_en_o  out  1  to PE weight_wr_en
pe_weight_addr_o  out  4  to PE weight_addr
pe_weight_o  out  dataWidth  to PE weight_i
x_valid_i  in  1  activation window valid
x_ready_o  out  1  activation window ready
x_data_i  in  windowElements*dataWidth  packed window, element 0 in LSBs
pe_data_o  out  windowElements*dataWidth  to PE data_i
pe_result_i  in  outputWidth  from PE data_o (combinational)
y_valid_o  out  1  result valid
y_ready_i  in  1  result ready
y_data_o  out  outputWidth  signed result

Behaviour:
- One clock, clk; reset nrst asynchronous active-low. Reset: state IDLE, all counters 0, busy_o/done_o/w_ready_o/x_ready_o/y_valid_o/pe_weight_wr_en_o = 0, y_data_o = 0.
- FSM IDLE -> LOAD -> COMPUTE -> DRAIN -> IDLE.
- IDLE: start_i latches num_windows_i. If num_windows_i == 0: done_o pulses the next cycle, and the FSM stays in IDLE with no weight load. Otherwise it enters LOAD.
- LOAD: w_ready_o = 1.
  - pe_weight_wr_en_o = w_valid_i & w_ready_o, combinationally.
  - pe_weight_addr_o = load counter; pe_weight_o = w_data_i.
  - The counter increments per handshake. The handshake at count windowElements-1 moves to COMPUTE and clears the counter.
- COMPUTE: pe_data_o = x_data_i, always passed through.
  - x_ready_o = !y_valid_o | y_ready_i, which gives full throughput with a single buffer.
  - On an x handshake, y_data_o <= pe_result_i and y_valid_o <= 1, so a result appears 1 cycle after the handshake.
  - A y handshake with no simultaneous x handshake clears y_valid_o. If both happen in the same cycle, the buffer reloads and y_valid_o stays 1.
  - The window counter increments per x handshake. The handshake on window num_windows-1 moves to DRAIN.
- DRAIN: x_ready_o = 0. When y_valid_o == 0, or a y handshake occurs this cycle: done_o = 1 for one cycle and the FSM returns to IDLE.
- Outside LOAD: w_ready_o = 0 and pe_weight_wr_en_o = 0. PE weights are never written in COMPUTE.
- Outside COMPUTE: x_ready_o = 0.
- start_i in any state other than IDLE is ignored.
- y_valid_o is held stable until accepted, and y_data_o does not change while y_valid_o=1 && !y_ready_i.
- Reset mid-operation aborts immediately; no done_o is generated. PE weights are cleared by the PE's own reset.

Optional Feature:
WSACC_PE_SEQ_WEIGHT_REUSE_EN:
- Enabled: adds input port reuse_i (1 bit) and an internal weights_loaded flag.
  - The flag is set when LOAD completes and cleared by reset.
  - start_i with reuse_i=1 and weights_loaded=1 goes IDLE -> COMPUTE, skipping LOAD.
  - reuse_i=1 with weights_loaded=0 performs a normal LOAD.
- Disabled: no reuse_i port; every nonzero start performs LOAD.

Test Plan:
- Load and compute: windowElements=9, weights 1..9, start num_windows=1, window all 2 -> 9 weight writes at addr 0..8, then y_data_o=90 one cycle after the x handshake, then done_o.
- Signed back-to-back: weights all -1, 4 windows of 127 with y_ready_i=1 tied -> x_ready_o stays 1, four results of -1143 on consecutive cycles, done_o after the last.
- Backpressure: y_ready_i=0 for 5 cycles after the first result -> x_ready_o=0, y_data_o held. Release -> the next window is accepted in the same cycle the result is taken.
- Zero windows: start with num_windows=0 -> no weight writes, done_o pulses exactly once, busy_o never asserts.
- Abort: assert nrst low during COMPUTE after 2 of 5 windows -> all outputs 0 and IDLE. A new start with num_windows=1 performs a full LOAD (9 writes).
- Reuse (macro on): after a normal run, start reuse_i=1 num_windows=2 -> zero weight writes, two correct results using the old weights.

Source files
------------

// File: rtl/wsacc_pe_seq.sv
// ---------------------------------------------------------------------------------------------
// wsacc_pe_seq
// Sequencer for a single weight-stationary PE. A job loads a windowElements-deep signed kernel
// from a valid/ready weight stream into the PE, then streams num_windows activation windows
// through the PE. Each combinational PE result is captured in a 1-entry valid/ready output
// buffer.
//
// Optional feature macro: WSACC_PE_SEQ_WEIGHT_REUSE_EN
//   Adds reuse_i. A start with reuse_i=1 skips LOAD when a kernel has already been loaded
//   since reset.
//
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   start_i, num_windows_i     job start (sampled in IDLE) and window count
//   busy_o, done_o             not-IDLE status, one-cycle completion pulse
//   w_valid_i/w_ready_o/w_data_i                weight stream
//   pe_weight_wr_en_o/pe_weight_addr_o/pe_weight_o  PE weight write port
//   x_valid_i/x_ready_o/x_data_i                activation window stream
//   pe_data_o, pe_result_i     PE data input, PE combinational result
//   y_valid_o/y_ready_i/y_data_o                result stream
// ---------------------------------------------------------------------------------------------
module wsacc_pe_seq #(
    parameter int unsigned dataWidth      = 8,
    parameter int unsigned outputWidth    = 32,
    parameter int unsigned windowElements = 9,
    parameter int unsigned countWidth     = 16
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                start_i,
`ifdef WSACC_PE_SEQ_WEIGHT_REUSE_EN
    input  logic                                reuse_i,
`endif
    input  logic [countWidth-1:0]               num_windows_i,
    output logic                                busy_o,
    output logic                                done_o,
    input  logic                                w_valid_i,
    output logic                                w_ready_o,
    input  logic [dataWidth-1:0]                w_data_i,
    output logic                                pe_weight_wr_en_o,
    output logic [3:0]                          pe_weight_addr_o,
    output logic [dataWidth-1:0]                pe_weight_o,
    input  logic                                x_valid_i,
    output logic                                x_ready_o,
    input  logic [windowElements*dataWidth-1:0] x_data_i,
    output logic [windowElements*dataWidth-1:0] pe_data_o,
    input  logic [outputWidth-1:0]              pe_result_i,
    output logic                                y_valid_o,
    input  logic                                y_ready_i,
    output logic [outputWidth-1:0]              y_data_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain
    } state_e;

    localparam logic [3:0] LastAddr = 4'(windowElements - 1);

    state_e                  state_q, state_d;
    logic [3:0]              load_cnt_q, load_cnt_d;
    logic [countWidth-1:0]   win_cnt_q, win_cnt_d;
    logic [countWidth-1:0]   num_win_q, num_win_d;
    logic                    done_zero_q, done_zero_d;
    logic                    y_valid_q, y_valid_d;
    logic [outputWidth-1:0]  y_data_q, y_data_d;
    logic                    skip_load;

    logic w_hs;
    logic x_hs;
    logic y_hs;
    logic drain_done;

`ifdef WSACC_PE_SEQ_WEIGHT_REUSE_EN
    logic weights_loaded_q, weights_loaded_d;
    assign skip_load = reuse_i & weights_loaded_q;
`else
    assign skip_load = 1'b0;
`endif

    // Handshakes and combinational outputs.
    assign w_ready_o         = (state_q == StLoad);
    assign w_hs              = w_valid_i & w_ready_o;
    assign pe_weight_wr_en_o = w_hs;
    assign pe_weight_addr_o  = load_cnt_q;
    assign pe_weight_o       = w_data_i;

    // A single buffer still sustains one window per cycle: a new window may enter whenever the
    // buffered result leaves in the same cycle.
    assign x_ready_o = (state_q == StCompute) & (~y_valid_q | y_ready_i);
    assign x_hs      = x_valid_i & x_ready_o;
    assign y_hs      = y_valid_q & y_ready_i;
    assign pe_data_o = x_data_i;

    assign drain_done = (state_q == StDrain) & (~y_valid_q | y_ready_i);

    // Zero-window jobs report completion from a register; drain completion is combinational so
    // the pulse lines up with the final result handshake.
    assign done_o    = done_zero_q | drain_done;
    assign busy_o    = (state_q != StIdle);
    assign y_valid_o = y_valid_q;
    assign y_data_o  = y_data_q;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        win_cnt_d   = win_cnt_q;
        num_win_d   = num_win_q;
        done_zero_d = 1'b0;
        y_valid_d   = y_valid_q;
        y_data_d    = y_data_q;
`ifdef WSACC_PE_SEQ_WEIGHT_REUSE_EN
        weights_loaded_d = weights_loaded_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    num_win_d  = num_windows_i;
                    win_cnt_d  = '0;
                    load_cnt_d = '0;
                    if (num_windows_i == '0) begin
                        done_zero_d = 1'b1;
                    end else if (skip_load) begin
                        state_d = StCompute;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (w_hs) begin
                    if (load_cnt_q == LastAddr) begin
                        load_cnt_d = '0;
                        state_d    = StCompute;
`ifdef WSACC_PE_SEQ_WEIGHT_REUSE_EN
                        weights_loaded_d = 1'b1;
`endif
                    end else begin
                        load_cnt_d = load_cnt_q + 4'd1;
                    end
                end
            end
            StCompute: begin
                if (x_hs) begin
                    if (win_cnt_q == num_win_q - countWidth'(1)) begin
                        win_cnt_d = '0;
                        state_d   = StDrain;
                    end else begin
                        win_cnt_d = win_cnt_q + countWidth'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Output buffer: a simultaneous load wins over the drain so valid stays high.
        if (x_hs) begin
            y_data_d  = pe_result_i;
            y_valid_d = 1'b1;
        end else if (y_hs) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            load_cnt_q  <= '0;
            win_cnt_q   <= '0;
            num_win_q   <= '0;
            done_zero_q <= 1'b0;
            y_valid_q   <= 1'b0;
            y_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            win_cnt_q   <= win_cnt_d;
            num_win_q   <= num_win_d;
            done_zero_q <= done_zero_d;
            y_valid_q   <= y_valid_d;
            y_data_q    <= y_data_d;
        end
    end

`ifdef WSACC_PE_SEQ_WEIGHT_REUSE_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            weights_loaded_q <= 1'b0;
        end else begin
            weights_loaded_q <= weights_loaded_d;
        end
    end
`endif

endmodule

// File: tb/tb_wsacc_pe_seq.sv
// ---------------------------------------------------------------------------------------------
// tb_wsacc_pe_seq
// Directed and randomized bench for wsacc_pe_seq with a behavioural PE attached. Expected
// results are dot products of the kernel and windows the bench generated itself.
// ---------------------------------------------------------------------------------------------
module tb_wsacc_pe_seq;

    localparam int DW   = 8;
    localparam int OW   = 32;
    localparam int WE   = 9;
    localparam int CW   = 16;
    localparam int MAXW = 8;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic              reuse_r = 1'b0;
    logic [CW-1:0]     num = '0;
    logic              busy_o, done_o;
    logic              w_valid = 1'b0;
    logic              w_ready_o;
    logic [DW-1:0]     w_data = '0;
    logic              pe_weight_wr_en_o;
    logic [3:0]        pe_weight_addr_o;
    logic [DW-1:0]     pe_weight_o;
    logic              x_valid = 1'b0;
    logic              x_ready_o;
    logic [WE*DW-1:0]  x_data = '0;
    logic [WE*DW-1:0]  pe_data;
    logic [OW-1:0]     pe_result;
    logic              y_valid_o;
    logic              y_ready = 1'b0;
    logic [OW-1:0]     y_data_o;

    always #5 clk = ~clk;

    wsacc_pe_seq #(
        .dataWidth      (DW),
        .outputWidth    (OW),
        .windowElements (WE),
        .countWidth     (CW)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .start_i           (start),
`ifdef WSACC_PE_SEQ_WEIGHT_REUSE_EN
        .reuse_i           (reuse_r),
`endif
        .num_windows_i     (num),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .w_valid_i         (w_valid),
        .w_ready_o         (w_ready_o),
        .w_data_i          (w_data),
        .pe_weight_wr_en_o (pe_weight_wr_en_o),
        .pe_weight_addr_o  (pe_weight_addr_o),
        .pe_weight_o       (pe_weight_o),
        .x_valid_i         (x_valid),
        .x_ready_o         (x_ready_o),
        .x_data_i          (x_data),
        .pe_data_o         (pe_data),
        .pe_result_i       (pe_result),
        .y_valid_o         (y_valid_o),
        .y_ready_i         (y_ready),
        .y_data_o          (y_data_o)
    );

    // Behavioural PE: weight register file plus combinational signed dot product.
    logic signed [DW-1:0] pe_w [16];

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 16; i++) pe_w[i] <= '0;
        end else if (pe_weight_wr_en_o) begin
            pe_w[pe_weight_addr_o] <= pe_weight_o;
        end
    end

    always_comb begin
        int acc;
        acc = 0;
        for (int e = 0; e < WE; e++) begin
            acc = acc + int'(pe_w[e]) * int'($signed(pe_data[e*DW +: DW]));
        end
        pe_result = OW'(acc);
    end

    int checks   = 0;
    int failures = 0;

    int  kern [WE];
    int  win  [MAXW][WE];
    int  wr_addr [$];
    int  wr_data [$];
    int  y_q [$];
    int  done_cnt = 0;
    bit  busy_seen = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WE*DW-1:0] pack(input int k);
        logic [WE*DW-1:0] p;
        p = '0;
        for (int e = 0; e < WE; e++) p[e*DW +: DW] = DW'(win[k][e]);
        return p;
    endfunction

    function automatic int dot(input int k);
        int s;
        s = 0;
        for (int e = 0; e < WE; e++) s += kern[e] * win[k][e];
        return s;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    // Monitor: samples on the falling edge, between input updates and the next active edge.
    initial begin
        bit               prev_hold;
        bit               prev_xhs;
        logic [OW-1:0]    prev_y;
        prev_hold = 1'b0;
        prev_xhs  = 1'b0;
        prev_y    = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_hold = 1'b0;
                prev_xhs  = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("y_hold_valid", y_valid_o, 1);
                    check("y_hold_data", $signed(y_data_o), $signed(prev_y));
                end
                if (prev_xhs) check("y_latency", y_valid_o, 1);
                if (pe_weight_wr_en_o) begin
                    wr_addr.push_back(int'(pe_weight_addr_o));
                    wr_data.push_back(int'($signed(pe_weight_o)));
                end
                if (y_valid_o && y_ready) y_q.push_back(int'($signed(y_data_o)));
                if (done_o) done_cnt++;
                if (busy_o) busy_seen = 1'b1;
                prev_hold = y_valid_o && !y_ready;
                prev_y    = y_data_o;
                prev_xhs  = x_valid && x_ready_o;
            end
        end
    end

    task automatic clear_obs();
        wr_addr.delete();
        wr_data.delete();
        y_q.delete();
        done_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    // Called at #1 after a rising edge; returns at #1 after the edge that samples start.
    task automatic pulse_start(input int n, input bit reuse);
        start   = 1'b1;
        num     = CW'(n);
        reuse_r = reuse;
        @(posedge clk);
        #1;
        start   = 1'b0;
        reuse_r = 1'b0;
    endtask

    task automatic load_weights(input int gap_pct);
        int widx;
        int budget;
        bit hs;
        widx   = 0;
        budget = 300;
        while (widx < WE && budget > 0) begin
            budget--;
            w_valid = ($urandom_range(99) >= gap_pct);
            w_data  = DW'(kern[widx]);
            @(negedge clk);
            hs = w_valid && w_ready_o;
            @(posedge clk);
            #1;
            if (hs) widx++;
        end
        w_valid = 1'b0;
        if (widx != WE) check("load_timeout", widx, WE);
    endtask

    task automatic stream(input int n, input int gap_pct, input int yr_pct,
                          output int iters, output int stalls);
        int xidx;
        bit fin;
        bit hs;
        xidx   = 0;
        fin    = 1'b0;
        iters  = 0;
        stalls = 0;
        while (!fin && iters < 600) begin
            iters++;
            x_valid = (xidx < n) && ($urandom_range(99) >= gap_pct);
            x_data  = pack((xidx < n) ? xidx : 0);
            y_ready = ($urandom_range(99) < yr_pct);
            @(negedge clk);
            hs  = x_valid && x_ready_o;
            fin = done_o;
            if (xidx < n && !x_ready_o) stalls++;
            @(posedge clk);
            #1;
            if (hs) xidx++;
        end
        x_valid = 1'b0;
        y_ready = 1'b0;
        check("stream_done", fin, 1);
    endtask

    task automatic check_job(input string tag, input int n, input bit loaded);
        if (loaded) begin
            check({tag, "_wr_count"}, wr_addr.size(), WE);
            for (int i = 0; i < WE && i < wr_addr.size(); i++) begin
                check({tag, "_wr_addr"}, wr_addr[i], i);
                check({tag, "_wr_data"}, wr_data[i], kern[i]);
            end
        end else begin
            check({tag, "_wr_count"}, wr_addr.size(), 0);
        end
        check({tag, "_y_count"}, y_q.size(), n);
        for (int k = 0; k < n && k < y_q.size(); k++) check({tag, "_y_data"}, y_q[k], dot(k));
        check({tag, "_done_count"}, done_cnt, 1);
    endtask

    task automatic run_job(input string tag, input int n, input int gap_pct, input int yr_pct,
                           input bit reuse, input bit loaded,
                           output int iters, output int stalls);
        clear_obs();
        pulse_start(n, reuse);
        if (loaded) load_weights(gap_pct);
        stream(n, gap_pct, yr_pct, iters, stalls);
        check_job(tag, n, loaded);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_w_ready"}, w_ready_o, 0);
        check({tag, "_x_ready"}, x_ready_o, 0);
        check({tag, "_y_valid"}, y_valid_o, 0);
        check({tag, "_wr_en"}, pe_weight_wr_en_o, 0);
        check({tag, "_y_data"}, y_data_o, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int iters;
        int stalls;
        bit fin;

        // Reset state.
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Load and compute: weights 1..9, one window of all 2 -> 90.
        for (int e = 0; e < WE; e++) begin
            kern[e]   = e + 1;
            win[0][e] = 2;
        end
        run_job("lc", 1, 0, 100, 1'b0, 1'b1, iters, stalls);
        check("lc_result90", (y_q.size() > 0) ? y_q[0] : 0, 90);

        // Signed back-to-back at full throughput.
        for (int e = 0; e < WE; e++) begin
            kern[e] = -1;
            for (int k = 0; k < 4; k++) win[k][e] = 127;
        end
        run_job("b2b", 4, 0, 100, 1'b0, 1'b1, iters, stalls);
        check("b2b_stalls", stalls, 0);
        check("b2b_cycles", iters, 5);
        check("b2b_last", (y_q.size() > 3) ? y_q[3] : 0, -1143);

        // Backpressure: hold the first result for 5 cycles, then release.
        for (int e = 0; e < WE; e++) begin
            kern[e] = rnd8();
            for (int k = 0; k < 2; k++) win[k][e] = rnd8();
        end
        clear_obs();
        pulse_start(2, 1'b0);
        load_weights(0);
        x_valid = 1'b1;
        x_data  = pack(0);
        y_ready = 1'b0;
        @(negedge clk);
        check("bp_first_xready", x_ready_o, 1);
        @(posedge clk);
        #1;
        x_data = pack(1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_xready_low", x_ready_o, 0);
            check("bp_y_valid", y_valid_o, 1);
            check("bp_y_data", $signed(y_data_o), dot(0));
            @(posedge clk);
            #1;
        end
        y_ready = 1'b1;
        @(negedge clk);
        check("bp_release_xready", x_ready_o, 1);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 20 && !fin; c++) begin
            @(negedge clk);
            fin = done_o;
            @(posedge clk);
            #1;
        end
        y_ready = 1'b0;
        check("bp_done_seen", fin, 1);
        check_job("bp", 2, 1'b1);

        // Zero windows.
        clear_obs();
        pulse_start(0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("zero_wr_count", wr_addr.size(), 0);
        check("zero_done_count", done_cnt, 1);
        check("zero_busy_seen", busy_seen, 0);
        check("zero_y_count", y_q.size(), 0);

        // Abort during compute after 2 of 5 windows.
        for (int e = 0; e < WE; e++) begin
            kern[e] = rnd8();
            for (int k = 0; k < 5; k++) win[k][e] = rnd8();
        end
        clear_obs();
        pulse_start(5, 1'b0);
        load_weights(0);
        y_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            x_valid = 1'b1;
            x_data  = pack(k);
            @(posedge clk);
            #1;
        end
        #2;
        nrst    = 1'b0;
        x_valid = 1'b0;
        y_ready = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        check("abort_no_done", done_cnt, 0);
        for (int e = 0; e < WE; e++) begin
            kern[e]   = rnd8();
            win[0][e] = rnd8();
        end
        run_job("after_abort", 1, 0, 100, 1'b0, 1'b1, iters, stalls);

        // Randomized jobs with gaps and random backpressure.
        for (int j = 0; j < 5; j++) begin
            int n;
            n = int'($urandom_range(MAXW, 1));
            for (int e = 0; e < WE; e++) begin
                kern[e] = rnd8();
                for (int k = 0; k < MAXW; k++) win[k][e] = rnd8();
            end
            run_job("rand", n, 30, 60, 1'b0, 1'b1, iters, stalls);
        end

`ifdef WSACC_PE_SEQ_WEIGHT_REUSE_EN
        // Reuse the kernel left by the last random job; only the windows change.
        for (int e = 0; e < WE; e++) begin
            for (int k = 0; k < 2; k++) win[k][e] = rnd8();
        end
        run_job("reuse", 2, 20, 70, 1'b1, 1'b0, iters, stalls);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
